// File: rtl/dac_serial_transmitter.sv
// Serial DAC word transmitter: parallel word in, MSB-first bit stream out with sclk/frame strobes.
// Optional one-word holding buffer enabled with `define DAC_TX_DOUBLE_BUFFER_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no frame in flight, serial outputs parked low
// ST_SHIFT | shifting WORD_WIDTH bits, one per CLK_DIV clk cycles
// ST_GAP   | one quiet bit period between frames
module dac_serial_transmitter #(
    parameter int WORD_WIDTH = 24,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WORD_WIDTH-1:0] parallel_in,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  dac_sclk,
    output logic                  dac_sdata,
    output logic                  dac_frame,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BIT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int PH_W  = $clog2(CLK_DIV);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_WIDTH - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(CLK_DIV / 2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [PH_W-1:0]       phase_q, phase_d;

    logic sclk_q, sclk_d;
    logic sdata_q, sdata_d;
    logic frame_q, frame_d;
    logic done_q, done_d;

    logic period_end;
    logic accept;
    logic direct_load;
    logic ready_c;

`ifdef DAC_TX_DOUBLE_BUFFER_EN
    logic [WORD_WIDTH-1:0] buf_q, buf_d;
    logic                  buf_full_q, buf_full_d;
    logic                  drain;
`endif

    always_comb begin
        period_end = (phase_q == PH_LAST);

`ifdef DAC_TX_DOUBLE_BUFFER_EN
        // The slot being vacated this cycle may be refilled on the same edge.
        drain       = (state_q == ST_GAP) && period_end && buf_full_q;
        ready_c     = !buf_full_q || drain;
        accept      = load_valid && ready_c;
        direct_load = accept && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_GAP) && period_end && !buf_full_q));
`else
        ready_c     = (state_q == ST_IDLE);
        accept      = load_valid && ready_c;
        direct_load = accept;
`endif

        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        phase_d = phase_q;
`ifdef DAC_TX_DOUBLE_BUFFER_EN
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (direct_load) begin
                    shift_d = parallel_in;
                    bit_d   = '0;
                    phase_d = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                phase_d = period_end ? '0 : phase_q + PH_W'(1);
                if (period_end) begin
                    shift_d = shift_q << 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = ST_GAP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                phase_d = period_end ? '0 : phase_q + PH_W'(1);
                if (period_end) begin
                    bit_d   = '0;
                    state_d = ST_IDLE;
`ifdef DAC_TX_DOUBLE_BUFFER_EN
                    if (buf_full_q) begin
                        shift_d = buf_q;
                        state_d = ST_SHIFT;
                    end else if (direct_load) begin
                        shift_d = parallel_in;
                        state_d = ST_SHIFT;
                    end
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                bit_d   = '0;
                phase_d = '0;
            end
        endcase

`ifdef DAC_TX_DOUBLE_BUFFER_EN
        if (drain) begin
            buf_full_d = 1'b0;
        end
        if (accept && !direct_load) begin
            buf_d      = parallel_in;
            buf_full_d = 1'b1;
        end
`endif

        // Serial pins are registered from next-state so they never glitch.
        sclk_d  = (state_d == ST_SHIFT) && (phase_d >= PH_HALF);
        sdata_d = (state_d == ST_SHIFT) && shift_d[WORD_WIDTH-1];
        frame_d = (state_d == ST_SHIFT) && (bit_d == '0);
        done_d  = (state_d == ST_SHIFT) && (bit_d == BIT_LAST) && (phase_d == PH_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            phase_q <= '0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            frame_q <= frame_d;
            done_q  <= done_d;
        end
    end

`ifdef DAC_TX_DOUBLE_BUFFER_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end
`endif

    assign load_ready = ready_c;
    assign dac_sclk   = sclk_q;
    assign dac_sdata  = sdata_q;
    assign dac_frame  = frame_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;

endmodule

// File: tb/tb_dac_serial_transmitter.sv
// Scoreboard bench for dac_serial_transmitter: instance A (CLK_DIV=4) and instance B (CLK_DIV=2).
// Buffer-specific scenarios follow `define DAC_TX_DOUBLE_BUFFER_EN.
module tb_dac_serial_transmitter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [23:0] pin_a, pin_b;
    logic        valid_a, valid_b;
    logic        ready_a, sclk_a, sdata_a, frame_a, busy_a, done_a;
    logic        ready_b, sclk_b, sdata_b, frame_b, busy_b, done_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] q_a[$];
    logic [23:0] q_b[$];

    logic [23:0] w;
    logic [4:0]  e5;
    logic        activity;

    dac_serial_transmitter #(.WORD_WIDTH(24), .CLK_DIV(4)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .parallel_in(pin_a), .load_valid(valid_a),
        .load_ready(ready_a), .dac_sclk(sclk_a), .dac_sdata(sdata_a),
        .dac_frame(frame_a), .busy(busy_a), .frame_done(done_a)
    );

    dac_serial_transmitter #(.WORD_WIDTH(24), .CLK_DIV(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .parallel_in(pin_b), .load_valid(valid_b),
        .load_ready(ready_b), .dac_sclk(sclk_b), .dac_sdata(sdata_b),
        .dac_frame(frame_b), .busy(busy_b), .frame_done(done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic wait_idle_a(input int max_cycles);
        int n = 0;
        while (busy_a !== 1'b0 && n < max_cycles) begin
            nxt();
            n++;
        end
        check("a_idle_wait", {31'd0, busy_a}, 32'd0);
    endtask

    // Monitor A: collect bits on sclk rising edges, compare at frame_done.
    initial begin : mon_a
        logic        prev = 1'b0;
        logic [23:0] acc  = '0;
        int          rises = 0;
        logic [23:0] exp_w;
        forever begin
            @(negedge clk);
            if (busy_a !== 1'b1) begin
                acc   = '0;
                rises = 0;
            end else begin
                if (sclk_a && !prev) begin
                    acc = {acc[22:0], sdata_a};
                    rises++;
                end
                if (done_a) begin
                    if (q_a.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL a_unexpected_frame: got frame %h expected no frame", acc);
                    end else begin
                        exp_w = q_a.pop_front();
                        check("a_frame_word", {8'd0, acc}, {8'd0, exp_w});
                        check("a_sclk_rises", rises, 24);
                    end
                    acc   = '0;
                    rises = 0;
                end
            end
            prev = sclk_a;
        end
    end

    initial begin : mon_b
        logic        prev = 1'b0;
        logic [23:0] acc  = '0;
        int          rises = 0;
        logic [23:0] exp_w;
        forever begin
            @(negedge clk);
            if (busy_b !== 1'b1) begin
                acc   = '0;
                rises = 0;
            end else begin
                if (sclk_b && !prev) begin
                    acc = {acc[22:0], sdata_b};
                    rises++;
                end
                if (done_b) begin
                    if (q_b.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL b_unexpected_frame: got frame %h expected no frame", acc);
                    end else begin
                        exp_w = q_b.pop_front();
                        check("b_frame_word", {8'd0, acc}, {8'd0, exp_w});
                        check("b_sclk_rises", rises, 24);
                    end
                    acc   = '0;
                    rises = 0;
                end
            end
            prev = sclk_b;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        reset_n = 1'b0;
        valid_a = 1'b0;
        pin_a   = '0;
        valid_b = 1'b0;
        pin_b   = '0;
        repeat (3) nxt();
        check("a_reset_state", {26'd0, ready_a, busy_a, sclk_a, sdata_a, frame_a, done_a}, 32'b100000);
        check("b_reset_state", {26'd0, ready_b, busy_b, sclk_b, sdata_b, frame_b, done_b}, 32'b100000);
        reset_n = 1'b1;
        nxt();

        // Single frame, full per-cycle waveform model
        w = 24'hA50F3C;
        pin_a = w;
        valid_a = 1'b1;
        q_a.push_back(w);
        nxt();
        valid_a = 1'b0;
        for (int k = 1; k <= 104; k++) begin
            e5 = {k <= 4, k <= 100, k == 96,
                  (k <= 96) && (((k - 1) % 4) >= 2),
                  (k <= 96) ? w[23 - (k - 1) / 4] : 1'b0};
            check($sformatf("a_wave_c%0d", k), {27'd0, frame_a, busy_a, done_a, sclk_a, sdata_a},
                  {27'd0, e5});
            nxt();
        end

        // Reset wins over a simultaneous accept
        reset_n = 1'b0;
        valid_a = 1'b1;
        pin_a   = 24'hFFFFFF;
        nxt();
        check("a_reset_priority", {29'd0, busy_a, frame_a, ready_a}, 32'b001);
        reset_n = 1'b1;
        valid_a = 1'b0;
        nxt();
        check("a_idle_after_reset", {31'd0, busy_a}, 32'd0);

`ifdef DAC_TX_DOUBLE_BUFFER_EN
        // Back-to-back through the holding buffer
        pin_a = 24'hFFFFFF;
        valid_a = 1'b1;
        q_a.push_back(24'hFFFFFF);
        nxt();
        check("a_ready_buf_empty", {31'd0, ready_a}, 32'd1);
        pin_a = 24'h000001;
        q_a.push_back(24'h000001);
        nxt();
        valid_a = 1'b0;
        pin_a = 24'hAAAAAA;
        for (int k = 2; k <= 101; k++) begin
            check($sformatf("a_ready_buf_c%0d", k), {31'd0, ready_a}, {31'd0, k >= 100});
            check($sformatf("a_frame_buf_c%0d", k), {31'd0, frame_a}, {31'd0, (k <= 4) || (k >= 101)});
            nxt();
        end
`else
        // load_valid held through SHIFT: no accept until IDLE, input churn ignored
        pin_a = 24'h123456;
        valid_a = 1'b1;
        q_a.push_back(24'h123456);
        nxt();
        for (int k = 1; k <= 101; k++) begin
            check($sformatf("a_ready_hold_c%0d", k), {31'd0, ready_a}, {31'd0, k >= 101});
            if (k == 101) begin
                check("a_idle_before_second", {31'd0, busy_a}, 32'd0);
                q_a.push_back(24'h0F0F0F);
            end
            pin_a = (k >= 96) ? 24'h0F0F0F : (((k % 2) != 0) ? 24'hFFFFFF : 24'h000000);
            nxt();
        end
        check("a_second_frame_start", {30'd0, frame_a, busy_a}, 32'b11);
        valid_a = 1'b0;
`endif
        wait_idle_a(300);
        nxt();

        // Reset at bit 10 with a second word pending
        pin_a = 24'hABCDEF;
        valid_a = 1'b1;
        nxt();
        pin_a = 24'h555555;
        repeat (40) nxt();
        check("a_bit10_in_frame", {30'd0, busy_a, frame_a}, 32'b10);
        reset_n = 1'b0;
        valid_a = 1'b0;
        nxt();
        check("a_reset_midframe", {26'd0, ready_a, busy_a, sclk_a, sdata_a, frame_a, done_a}, 32'b100000);
        reset_n = 1'b1;
        activity = 1'b0;
        repeat (130) begin
            nxt();
            activity = activity | busy_a | sdata_a | sclk_a | frame_a | done_a;
        end
        check("a_no_resume", {31'd0, activity}, 32'd0);

        // CLK_DIV=2, single MSB set
        pin_b = 24'h800000;
        valid_b = 1'b1;
        q_b.push_back(24'h800000);
        nxt();
        valid_b = 1'b0;
        for (int k = 1; k <= 52; k++) begin
            e5 = {k <= 2, k <= 50, k == 48,
                  (k <= 48) && (((k - 1) % 2) == 1),
                  k <= 2};
            check($sformatf("b_wave_c%0d", k), {27'd0, frame_b, busy_b, done_b, sclk_b, sdata_b},
                  {27'd0, e5});
            nxt();
        end

        repeat (3) nxt();
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
